// File: rtl/remote_comm_pkg.sv
// Shared types and defaults for the remote_comm command link.
// Optional feature macro: REMOTE_COMM_FRM_ERR_EN (stop-bit framing check).
package remote_comm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND_HI,
      SEND_LO
   } cmd_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam int BAUD_DIV_DEFAULT = 434;
   localparam int BAUD_CNT_W       = 12;

endpackage

// File: rtl/remote_comm_uart.sv
// rc_uart: 8N1 transmitter and receiver sharing one baud divisor.
// With REMOTE_COMM_FRM_ERR_EN the stop bit is checked and frm_err is added.
module rc_uart
   import remote_comm_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_done,
   output logic       TX,
   input  logic       RX,
   output logic       rx_rdy,
   output logic [7:0] rx_data,
   output logic       rx_sof
`ifdef REMOTE_COMM_FRM_ERR_EN
   ,
   output logic       frm_err
`endif
);

   localparam logic [BAUD_CNT_W-1:0] BIT_LAST  = BAUD_CNT_W'(BAUD_DIV - 1);
   localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(BAUD_DIV / 2 - 1);

   logic                  tx_busy_q, tx_busy_d;
   logic [BAUD_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]            tx_bit_q, tx_bit_d;
   logic [8:0]            tx_shift_q, tx_shift_d;
   logic                  tx_q, tx_d;
   logic                  tx_bit_end;

   logic                  rx_s1_q, rx_s2_q, rx_s3_q;
   rx_state_t             rx_state_q, rx_state_d;
   logic [BAUD_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]            rx_bit_q, rx_bit_d;
   logic [7:0]            rx_shift_q, rx_shift_d;
   logic [7:0]            rx_data_q, rx_data_d;
   logic                  rx_rdy_q, rx_rdy_d;
   logic                  rx_sof_q, rx_sof_d;
   logic                  frm_err_q, frm_err_d;
   logic                  rx_fall;

   assign tx_bit_end = tx_busy_q && (tx_cnt_q == BIT_LAST);
   assign tx_done    = tx_bit_end && (tx_bit_q == 4'd9);
   assign TX         = tx_q;

   // A new frame may load on the last stop-bit clock so back-to-back bytes have no gap.
   always_comb begin
      tx_busy_d  = tx_busy_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_d       = tx_q;
      if (tx_busy_q) begin
         if (tx_bit_end) begin
            tx_cnt_d = '0;
            if (tx_bit_q == 4'd9) begin
               tx_busy_d = 1'b0;
               tx_d      = 1'b1;
            end else begin
               tx_d       = tx_shift_q[0];
               tx_shift_d = {1'b1, tx_shift_q[8:1]};
               tx_bit_d   = tx_bit_q + 4'd1;
            end
         end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
         end
      end
      if (tx_start && (!tx_busy_q || tx_done)) begin
         tx_busy_d  = 1'b1;
         tx_d       = 1'b0;
         tx_cnt_d   = '0;
         tx_bit_d   = '0;
         tx_shift_d = {1'b1, tx_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_busy_q  <= 1'b0;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '1;
         tx_q       <= 1'b1;
      end else begin
         tx_busy_q  <= tx_busy_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
      end
   end

   assign rx_fall = rx_s3_q && !rx_s2_q;
   assign rx_rdy  = rx_rdy_q;
   assign rx_data = rx_data_q;
   assign rx_sof  = rx_sof_q;
`ifdef REMOTE_COMM_FRM_ERR_EN
   assign frm_err = frm_err_q;
`endif

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_rdy_d   = 1'b0;
      rx_sof_d   = 1'b0;
      frm_err_d  = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_fall) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
               rx_sof_d   = 1'b1;
            end
         end
         RX_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
`ifdef REMOTE_COMM_FRM_ERR_EN
               if (rx_s2_q) begin
                  rx_rdy_d  = 1'b1;
                  rx_data_d = rx_shift_q;
               end else begin
                  frm_err_d = 1'b1;
               end
`else
               rx_rdy_d  = 1'b1;
               rx_data_d = rx_shift_q;
`endif
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_s3_q    <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_rdy_q   <= 1'b0;
         rx_sof_q   <= 1'b0;
         frm_err_q  <= 1'b0;
      end else begin
         rx_s1_q    <= RX;
         rx_s2_q    <= rx_s1_q;
         rx_s3_q    <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_rdy_q   <= rx_rdy_d;
         rx_sof_q   <= rx_sof_d;
         frm_err_q  <= frm_err_d;
      end
   end

endmodule

// File: rtl/remote_comm.sv
// remote_comm: sends a 16-bit command as two UART bytes and latches response bytes.
// Optional feature macro: REMOTE_COMM_FRM_ERR_EN adds the frm_err output.
module remote_comm
   import remote_comm_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cmd,
   input  logic        send_cmd,
   output logic        cmd_sent,
   output logic        TX,
   input  logic        RX,
   output logic [7:0]  resp,
   output logic        resp_rdy,
   input  logic        clr_resp_rdy
`ifdef REMOTE_COMM_FRM_ERR_EN
   ,
   output logic        frm_err
`endif
);

   cmd_state_t  state_q, state_d;
   logic [15:0] cmd_q, cmd_d;
   logic        cmd_sent_q, cmd_sent_d;
   logic        done_pend_q, done_pend_d;
   logic [7:0]  resp_q, resp_d;
   logic        resp_rdy_q, resp_rdy_d;
   logic        tx_start, tx_done;
   logic [7:0]  tx_data;
   logic        rx_rdy, rx_sof;
   logic [7:0]  rx_data;

   rc_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
      .clk      (clk),
      .rst      (rst),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_done  (tx_done),
      .TX       (TX),
      .RX       (RX),
      .rx_rdy   (rx_rdy),
      .rx_data  (rx_data),
      .rx_sof   (rx_sof)
`ifdef REMOTE_COMM_FRM_ERR_EN
      ,
      .frm_err  (frm_err)
`endif
   );

   // done_pend delays cmd_sent one cycle past the low byte's stop bit.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      cmd_sent_d  = cmd_sent_q;
      done_pend_d = 1'b0;
      tx_start    = 1'b0;
      tx_data     = cmd_q[15:8];
      case (state_q)
         IDLE: begin
            if (send_cmd) begin
               cmd_d      = cmd;
               cmd_sent_d = 1'b0;
               tx_start   = 1'b1;
               tx_data    = cmd[15:8];
               state_d    = SEND_HI;
            end else if (done_pend_q) begin
               cmd_sent_d = 1'b1;
            end
         end
         SEND_HI: begin
            tx_start = tx_done;
            tx_data  = cmd_q[7:0];
            if (tx_done) state_d = SEND_LO;
         end
         SEND_LO: begin
            if (tx_done) begin
               state_d     = IDLE;
               done_pend_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      resp_d     = resp_q;
      resp_rdy_d = resp_rdy_q;
      if (rx_rdy) begin
         resp_d     = rx_data;
         resp_rdy_d = 1'b1;
      end else if (clr_resp_rdy || rx_sof) begin
         resp_rdy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         cmd_sent_q  <= 1'b0;
         done_pend_q <= 1'b0;
         resp_q      <= '0;
         resp_rdy_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         cmd_sent_q  <= cmd_sent_d;
         done_pend_q <= done_pend_d;
         resp_q      <= resp_d;
         resp_rdy_q  <= resp_rdy_d;
      end
   end

   assign cmd_sent = cmd_sent_q;
   assign resp     = resp_q;
   assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// Directed + randomized bench for remote_comm at BAUD_DIV=16, TX optionally looped to RX.
// Define REMOTE_COMM_FRM_ERR_EN to also exercise the framing-error output.
module tb_remote_comm;

   localparam int B = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cmd = '0;
   logic        send_cmd = 1'b0;
   logic        cmd_sent;
   logic        tx_w;
   logic        rx_w;
   logic [7:0]  resp;
   logic        resp_rdy;
   logic        clr_resp_rdy = 1'b0;
   logic        loopback = 1'b1;
   logic        bench_rx = 1'b1;
`ifdef REMOTE_COMM_FRM_ERR_EN
   logic        frm_err;
`endif

   int checks = 0;
   int failures = 0;

   logic [7:0] got_q[$];
   logic       rdy_prev = 1'b0;
   int         frm_cnt = 0;

   assign rx_w = loopback ? tx_w : bench_rx;

   remote_comm #(.BAUD_DIV(B)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd          (cmd),
      .send_cmd     (send_cmd),
      .cmd_sent     (cmd_sent),
      .TX           (tx_w),
      .RX           (rx_w),
      .resp         (resp),
      .resp_rdy     (resp_rdy),
      .clr_resp_rdy (clr_resp_rdy)
`ifdef REMOTE_COMM_FRM_ERR_EN
      ,
      .frm_err      (frm_err)
`endif
   );

   always #5 clk = ~clk;

   // Record every rising edge of resp_rdy along with the byte it presents.
   always @(negedge clk) begin
      if (resp_rdy && !rdy_prev) got_q.push_back(resp);
      rdy_prev = resp_rdy;
`ifdef REMOTE_COMM_FRM_ERR_EN
      if (frm_err) frm_cnt++;
`endif
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic uart_send(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         bench_rx = frame[i];
         step(B);
      end
      bench_rx = 1'b1;
   endtask

   task automatic pulse_clr();
      clr_resp_rdy = 1'b1;
      step(1);
      clr_resp_rdy = 1'b0;
   endtask

   // Send c, decode the wire at mid-bit, check framing, bytes, cmd_sent latency and loopback bytes.
   task automatic send_check(input logic [15:0] c, input bit inject, input logic [15:0] junk);
      logic [19:0] bits;
      logic [7:0]  hi, lo;
      int          cyc, base;
      hi = c[15:8];
      lo = c[7:0];
      base = got_q.size();
      cmd = c;
      send_cmd = 1'b1;
      step(1);
      send_cmd = 1'b0;
      cmd = 16'($urandom);
      cyc = 0;
      check("cmd_sent_cleared", 32'(cmd_sent), 32'd0);
      for (int k = 0; k < 20; k++) begin
         while (cyc < k * B + B / 2) begin
            if (inject && cyc == 5 * B) begin
               send_cmd = 1'b1;
               cmd = junk;
            end
            step(1);
            cyc++;
            send_cmd = 1'b0;
         end
         bits[k] = tx_w;
      end
      check("hi_start", 32'(bits[0]), 32'd0);
      check("hi_byte", 32'(bits[8:1]), 32'(hi));
      check("hi_stop", 32'(bits[9]), 32'd1);
      check("lo_start", 32'(bits[10]), 32'd0);
      check("lo_byte", 32'(bits[18:11]), 32'(lo));
      check("lo_stop", 32'(bits[19]), 32'd1);
      while (!cmd_sent && cyc < 20 * B + 40) begin
         step(1);
         cyc++;
      end
      check("cmd_sent_latency", 32'(cyc), 32'(20 * B + 1));
      if (loopback) begin
         step(4);
         check("loop_rx_count", 32'(got_q.size() - base), 32'd2);
         if (got_q.size() - base >= 2) begin
            check("loop_rx_hi", 32'(got_q[base]), 32'(hi));
            check("loop_rx_lo", 32'(got_q[base + 1]), 32'(lo));
         end
         check("loop_resp_rdy", 32'(resp_rdy), 32'd1);
         check("loop_resp", 32'(resp), 32'(lo));
      end
   endtask

   initial begin
      logic [7:0]  b;
      logic [15:0] c;
      int          base;

      step(3);
      rst = 1'b0;
      check("rst_tx", 32'(tx_w), 32'd1);
      check("rst_cmd_sent", 32'(cmd_sent), 32'd0);
      check("rst_resp_rdy", 32'(resp_rdy), 32'd0);
      check("rst_resp", 32'(resp), 32'd0);
      step(2);

      // Directed send with an ignored mid-frame request.
      send_check(16'h4001, 1'b1, 16'hFFFF);
      check("cmd_sent_holds", 32'(cmd_sent), 32'd1);

      // Loopback with two distinct bytes; resp_rdy must clear at the second start bit.
      send_check(16'h6022, 1'b0, 16'h0000);

      for (int i = 0; i < 4; i++) begin
         c = 16'($urandom);
         send_check(c, 1'b1, 16'($urandom));
      end

      // Bench-driven responses.
      loopback = 1'b0;
      step(2);
      uart_send(8'hA5, 1'b1);
      step(4);
      check("rx_rdy_a5", 32'(resp_rdy), 32'd1);
      check("rx_resp_a5", 32'(resp), 32'hA5);
      pulse_clr();
      check("clr_rdy", 32'(resp_rdy), 32'd0);
      check("clr_keeps_resp", 32'(resp), 32'hA5);
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom);
         uart_send(b, 1'b1);
         step(4);
         check("rx_rdy_rand", 32'(resp_rdy), 32'd1);
         check("rx_resp_rand", 32'(resp), 32'(b));
         pulse_clr();
         check("clr_rdy_rand", 32'(resp_rdy), 32'd0);
      end

      // Short low glitch must not produce a byte.
      base = got_q.size();
      bench_rx = 1'b0;
      step(3);
      bench_rx = 1'b1;
      step(3 * B);
      check("glitch_rdy", 32'(resp_rdy), 32'd0);
      check("glitch_no_rise", 32'(got_q.size() - base), 32'd0);

      // Reset while both a command and a received byte are in flight.
      uart_send(8'hA5, 1'b1);
      step(4);
      check("pre_rst_rdy", 32'(resp_rdy), 32'd1);
      cmd = 16'h0000;
      send_cmd = 1'b1;
      step(1);
      send_cmd = 1'b0;
      step(99);
      check("pre_rst_tx_low", 32'(tx_w), 32'd0);
      bench_rx = 1'b0;
      step(B + 3);
      rst = 1'b1;
      step(1);
      check("mid_rst_tx", 32'(tx_w), 32'd1);
      check("mid_rst_cmd_sent", 32'(cmd_sent), 32'd0);
      check("mid_rst_resp_rdy", 32'(resp_rdy), 32'd0);
      check("mid_rst_resp", 32'(resp), 32'd0);
      rst = 1'b0;
      bench_rx = 1'b1;
      step(4);

      loopback = 1'b1;
      step(2);
      send_check(16'($urandom), 1'b0, 16'h0000);

`ifdef REMOTE_COMM_FRM_ERR_EN
      loopback = 1'b0;
      pulse_clr();
      base = frm_cnt;
      uart_send(8'h5A, 1'b0);
      step(4);
      check("frm_err_pulses", 32'(frm_cnt - base), 32'd1);
      check("frm_err_no_rdy", 32'(resp_rdy), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
